// File: rtl/segmentation_sequencer.sv
// Block-raster read sequencer for the segmentation image memory; owns the single memory port.
// Latency: first word valid 2 cycles after start is sampled; then one word per cycle.
// Backpressure: valid/ready; a stall re-reads the held address so memory dout stays stable.
module segmentation_sequencer #(
  parameter int DIM   = 8,
  parameter int IMG_W = 256,
  parameter int IMG_H = 256,
  parameter int DEPTH = 8192,
  parameter int ADDR  = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic            host_we,
  input  logic [ADDR-1:0] host_addr,
  input  logic            ready_in,
  output logic [ADDR-1:0] mem_addr,
  output logic            mem_we,
  output logic            valid_out,
  output logic            block_first,
  output logic            block_last,
  output logic            frame_last,
  output logic            busy,
  output logic            done,
  output logic            host_wr_err
);

  localparam int WPR = IMG_W / DIM;
  localparam int BH  = IMG_H / DIM;
  localparam int RW  = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int XW  = (WPR > 1) ? $clog2(WPR) : 1;
  localparam int YW  = (BH > 1) ? $clog2(BH) : 1;

  localparam logic [RW-1:0] R_LAST  = RW'(DIM - 1);
  localparam logic [XW-1:0] BX_LAST = XW'(WPR - 1);
  localparam logic [YW-1:0] BY_LAST = YW'(BH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic first;
    logic last;
    logic frame_end;
  } tag_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   r_q, r_d;
  logic [XW-1:0]   bx_q, bx_d;
  logic [YW-1:0]   by_q, by_d;
  logic [ADDR-1:0] rd_addr_q, rd_addr_d;
  logic            rd_vld_q, rd_vld_d;
  tag_t            tag_q, tag_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic            stall;
  logic            at_r_last;
  logic            at_bx_last;
  logic            at_by_last;
  logic            frame_end;
  logic [ADDR-1:0] issue_addr;

  assign stall      = rd_vld_q && !ready_in;
  assign at_r_last  = (r_q == R_LAST);
  assign at_bx_last = (bx_q == BX_LAST);
  assign at_by_last = (by_q == BY_LAST);
  assign frame_end  = at_r_last && at_bx_last && at_by_last;

  // Word address of row r inside block (bx, by): rows of the frame are WPR words apart.
  assign issue_addr = (ADDR'(by_q) * ADDR'(DIM) + ADDR'(r_q)) * ADDR'(WPR) + ADDR'(bx_q);

  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    bx_d      = bx_q;
    by_d      = by_q;
    rd_addr_d = rd_addr_q;
    rd_vld_d  = rd_vld_q;
    tag_d     = tag_q;
    done_d    = 1'b0;
    err_d     = host_we && (state_q != IDLE);
    mem_addr  = rd_addr_q;
    mem_we    = 1'b0;

    case (state_q)
      IDLE: begin
        mem_addr = host_addr;
        mem_we   = host_we;
        if (start) begin
          state_d = RUN;
        end
      end

      RUN: begin
        if (!stall) begin
          mem_addr        = issue_addr;
          rd_addr_d       = issue_addr;
          rd_vld_d        = 1'b1;
          tag_d.first     = (r_q == '0);
          tag_d.last      = at_r_last;
          tag_d.frame_end = frame_end;
          if (!at_r_last) begin
            r_d = r_q + RW'(1);
          end else begin
            r_d = '0;
            if (!at_bx_last) begin
              bx_d = bx_q + XW'(1);
            end else begin
              bx_d = '0;
              by_d = at_by_last ? '0 : by_q + YW'(1);
            end
          end
          if (frame_end) begin
            state_d = DRAIN;
          end
        end
      end

      DRAIN: begin
        // Only the final word is outstanding here, so any non-stalled cycle retires it.
        if (!stall) begin
          rd_vld_d = 1'b0;
          tag_d    = '0;
          state_d  = IDLE;
          done_d   = rd_vld_q && ready_in && tag_q.frame_end;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort) begin
      state_d   = IDLE;
      r_d       = '0;
      bx_d      = '0;
      by_d      = '0;
      rd_addr_d = '0;
      rd_vld_d  = 1'b0;
      tag_d     = '0;
      done_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      r_q       <= '0;
      bx_q      <= '0;
      by_q      <= '0;
      rd_addr_q <= '0;
      rd_vld_q  <= 1'b0;
      tag_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      bx_q      <= bx_d;
      by_q      <= by_d;
      rd_addr_q <= rd_addr_d;
      rd_vld_q  <= rd_vld_d;
      tag_q     <= tag_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign valid_out   = rd_vld_q;
  assign block_first = rd_vld_q && tag_q.first;
  assign block_last  = rd_vld_q && tag_q.last;
  assign frame_last  = rd_vld_q && tag_q.frame_end;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign host_wr_err = err_q;

endmodule

// File: tb/tb_segmentation_sequencer.sv
// Bench for segmentation_sequencer: a 16x16 and a default 256x256 instance share stimulus;
// accepted words are scored against an ordered list of expected block-raster addresses and tags.
module tb_segmentation_sequencer;

  localparam int DIM = 8;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, abort, host_we, ready_in, sel;
  logic [12:0] host_addr;

  logic [4:0]  s_mem_addr;
  logic        s_we, s_valid, s_first, s_last, s_flast, s_busy, s_done, s_err;
  logic [12:0] l_mem_addr;
  logic        l_we, l_valid, l_first, l_last, l_flast, l_busy, l_done, l_err;

  logic [31:0] dout_s, dout_l, o_dout, o_mem_addr;
  logic        o_we, o_valid, o_first, o_last, o_flast, o_busy, o_done, o_err;

  int vectors = 0;
  int miscompares = 0;

  int exp_addr[$];
  bit exp_first[$];
  bit exp_last[$];
  bit exp_flast[$];

  segmentation_sequencer #(.DIM(8), .IMG_W(16), .IMG_H(16), .DEPTH(32)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start & ~sel), .abort(abort),
    .host_we(host_we), .host_addr(host_addr[4:0]), .ready_in(ready_in),
    .mem_addr(s_mem_addr), .mem_we(s_we), .valid_out(s_valid),
    .block_first(s_first), .block_last(s_last), .frame_last(s_flast),
    .busy(s_busy), .done(s_done), .host_wr_err(s_err)
  );

  segmentation_sequencer dut_l (
    .clk(clk), .rst_n(rst_n), .start(start & sel), .abort(abort),
    .host_we(host_we), .host_addr(host_addr), .ready_in(ready_in),
    .mem_addr(l_mem_addr), .mem_we(l_we), .valid_out(l_valid),
    .block_first(l_first), .block_last(l_last), .frame_last(l_flast),
    .busy(l_busy), .done(l_done), .host_wr_err(l_err)
  );

  // Read-only memory image: distinct, address-derived content for every word.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h0000_1357;
  endfunction

  always @(posedge clk) begin
    dout_s <= mem_f(32'(s_mem_addr));
    dout_l <= mem_f(32'(l_mem_addr));
  end

  assign o_mem_addr = sel ? 32'(l_mem_addr) : 32'(s_mem_addr);
  assign o_dout     = sel ? dout_l  : dout_s;
  assign o_we       = sel ? l_we    : s_we;
  assign o_valid    = sel ? l_valid : s_valid;
  assign o_first    = sel ? l_first : s_first;
  assign o_last     = sel ? l_last  : s_last;
  assign o_flast    = sel ? l_flast : s_flast;
  assign o_busy     = sel ? l_busy  : s_busy;
  assign o_done     = sel ? l_done  : s_done;
  assign o_err      = sel ? l_err   : s_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected frame as an ordered word list: blocks left-to-right, top-to-bottom, rows within a block.
  function automatic void build_model(input bit big);
    int w, h, wpr;
    w   = big ? 256 : 16;
    h   = big ? 256 : 16;
    wpr = w / DIM;
    exp_addr.delete();
    exp_first.delete();
    exp_last.delete();
    exp_flast.delete();
    for (int by = 0; by < h / DIM; by++)
      for (int bx = 0; bx < wpr; bx++)
        for (int r = 0; r < DIM; r++) begin
          exp_addr.push_back((by * DIM + r) * wpr + bx);
          exp_first.push_back(r == 0);
          exp_last.push_back(r == DIM - 1);
          exp_flast.push_back((by == h / DIM - 1) && (bx == wpr - 1) && (r == DIM - 1));
        end
  endfunction

  // mode: 0 ready high, 1 random ready, 2 ready low for 3 cycles on the word at address 4.
  task automatic run_frame(input bit big, input int mode, input int we_cyc,
                           input int restart_cyc, input int abort_addr, input int budget);
    int nw, k, cyc, tail, n_done, n_bl, n_fl, stall_left;
    bit done_due, stall_done, exact, ended, prev_stall;
    nw = big ? (256 * 256 / DIM) : (16 * 16 / DIM);
    build_model(big);
    k = 0; cyc = 0; tail = 0; n_done = 0; n_bl = 0; n_fl = 0; stall_left = 0;
    done_due = 0; stall_done = 0; ended = 0; prev_stall = 0;
    exact = !big && mode == 0 && we_cyc < 0 && restart_cyc < 0 && abort_addr < 0;
    sel = big;
    while (cyc < budget && tail <= 3) begin
      start     = (cyc == 0) || (cyc == restart_cyc);
      host_we   = (cyc == we_cyc);
      host_addr = 13'($urandom_range(0, 8191));
      abort     = (abort_addr >= 0) && !ended && o_valid && k < nw && exp_addr[k] == abort_addr;
      if (mode == 2 && !stall_done && stall_left == 0 && o_valid && k < nw && exp_addr[k] == 4)
        stall_left = 3;
      case (mode)
        1:       ready_in = 1'($urandom_range(0, 1));
        2:       ready_in = (stall_left == 0);
        default: ready_in = 1'b1;
      endcase

      @(negedge clk);
      chk("done", 32'(o_done), 32'(done_due));
      if (o_done) n_done++;
      done_due = 0;
      chk("busy", 32'(o_busy), 32'(cyc >= 1 && tail == 0));
      chk("wr_err", 32'(o_err), 32'(we_cyc >= 0 && cyc == we_cyc + 1));
      if (cyc == we_cyc) chk("we_run", 32'(o_we), 0);
      if (tail >= 1) chk("vld_end", 32'(o_valid), 0);
      if (exact) begin
        chk("valid_t", 32'(o_valid), 32'(cyc >= 2 && cyc <= nw + 1));
        chk("done_t", 32'(o_done), 32'(cyc == nw + 2));
        if (cyc >= 1 && cyc <= nw) chk("issue_addr", o_mem_addr, 32'(exp_addr[cyc - 1]));
      end
      if (prev_stall) chk("stall_vld", 32'(o_valid), 1);
      if (k >= nw) chk("extra_vld", 32'(o_valid), 0);
      if (o_valid && k < nw) begin
        chk("dout", o_dout, mem_f(32'(exp_addr[k])));
        chk("first", 32'(o_first), 32'(exp_first[k]));
        chk("last", 32'(o_last), 32'(exp_last[k]));
        chk("flast", 32'(o_flast), 32'(exp_flast[k]));
        if (!ready_in && !abort) chk("stall_addr", o_mem_addr, 32'(exp_addr[k]));
      end
      prev_stall = o_valid && !ready_in && !abort;
      if (abort) begin
        ended = 1;
      end else if (o_valid && ready_in && k < nw) begin
        n_bl += int'(o_last);
        n_fl += int'(o_flast);
        k++;
        if (k == nw) begin
          done_due = 1;
          ended    = 1;
        end
      end

      @(posedge clk);
      #1;
      if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) stall_done = 1;
      end
      if (ended) tail++;
      cyc++;
    end
    start = 0; host_we = 0; abort = 0; ready_in = 1;
    chk("finished", 32'(tail > 3), 1);
    if (abort_addr < 0) begin
      chk("n_acc", k, nw);
      chk("n_blast", n_bl, nw / DIM);
      chk("n_flast", n_fl, 1);
      chk("n_done", n_done, 1);
    end else begin
      chk("n_done_abort", n_done, 0);
    end
  endtask

  initial begin
    logic [12:0] a;
    rst_n = 0; start = 0; abort = 0; host_we = 0; host_addr = '0; ready_in = 1; sel = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      sel = 1'(i);
      #1;
      chk("rst_valid", 32'(o_valid), 0);
      chk("rst_busy", 32'(o_busy), 0);
      chk("rst_done", 32'(o_done), 0);
      chk("rst_err", 32'(o_err), 0);
      chk("rst_tags", {29'd0, o_first, o_last, o_flast}, 0);
    end
    sel = 0;
    @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk);
    #1;

    // Host port ownership while idle.
    host_we = 1; host_addr = 13'd5;
    @(negedge clk);
    chk("idle_addr", o_mem_addr, 5);
    chk("idle_we", 32'(o_we), 1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      a = 13'($urandom_range(0, 31));
      host_addr = a;
      host_we = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("idle_addr_r", o_mem_addr, 32'(a));
      chk("idle_we_r", 32'(o_we), 32'(host_we));
    end
    @(posedge clk);
    #1 host_we = 0;
    @(negedge clk);
    chk("idle_err", 32'(o_err), 0);
    @(posedge clk);
    #1;

    run_frame(0, 0, -1, -1, -1, 200);
    run_frame(0, 2, -1, -1, -1, 200);
    run_frame(0, 1, 10, 15, -1, 400);
    run_frame(0, 1, -1, -1, 18, 400);
    run_frame(0, 0, -1, -1, -1, 200);

    // Reset in the middle of a frame acts immediately.
    sel = 0; ready_in = 1; start = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (5) @(posedge clk);
    #1;
    @(negedge clk);
    chk("pre_rst_busy", 32'(o_busy), 1);
    chk("pre_rst_vld", 32'(o_valid), 1);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_vld", 32'(o_valid), 0);
    chk("mid_rst_busy", 32'(o_busy), 0);
    chk("mid_rst_tags", {29'd0, o_first, o_last, o_flast}, 0);
    @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk);
    #1;

    run_frame(0, 1, -1, -1, -1, 400);
    run_frame(1, 1, -1, -1, -1, 60000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/segmentation_sequencer.md
Name: segmentation_sequencer

Overview:
Block-raster read sequencer and memory-port arbiter for the segmentation image memory. It replaces the free-running 8-on/8-off enable with a start-triggered walk over the stored frame, DIM x DIM block by block. It issues one memory word address per cycle with valid/ready backpressure toward the compressor. Outside a frame it grants the single memory address/write port to host writes.

Parameters:
DIM, 8, pixels per memory word and block edge length
IMG_W, 256, frame width in pixels (multiple of DIM)
IMG_H, 256, frame height in pixels (multiple of DIM)
DEPTH, 8192, memory depth in words; IMG_W*IMG_H/DIM <= DEPTH
ADDR, $clog2(DEPTH), address width

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  frame start pulse; honoured only in IDLE
abort  in  1  terminate frame immediately
host_we  in  1  host write request
host_addr  in  ADDR  host write address
ready_in  in  1  downstream accepts current word
mem_addr  out  ADDR  memory address (combinational mux)
mem_we  out  1  memory write enable
valid_out  out  1  memory dout holds a sequenced word
block_first  out  1  with valid_out: row 0 of a block
block_last  out  1  with valid_out: row DIM-1 of a block
frame_last  out  1  with valid_out: final word of frame
busy  out  1  state != IDLE
done  out  1  one-cycle pulse, frame fully accepted
host_wr_err  out  1  one-cycle pulse, host write refused

Behaviour:
- The single clock is clk. Reset is asynchronous and active-low on rst_n. Reset forces state IDLE, all counters 0, and valid_out/block_first/block_last/frame_last/done/host_wr_err/busy to 0.
- Memory model: synchronous read. dout in cycle t+1 = mem[mem_addr in cycle t].
- WPR = IMG_W/DIM. Counters: by (0..IMG_H/DIM-1), bx (0..WPR-1), r (0..DIM-1).
- Issue address = (by*DIM + r)*WPR + bx.
- Advance order: r fastest, then bx, then by. Each counter wraps to 0 when its higher counter increments.
- Registers: rd_addr_q (last issued address) and rd_vld_q. valid_out = rd_vld_q.
- Tag registers block_first/block_last/frame_last are captured with the issue and qualified by valid_out.
- stall = valid_out && !ready_in.
- States:
  - IDLE: mem_addr = host_addr, mem_we = host_we. start -> RUN; host write in the same cycle still completes.
  - RUN, stall: mem_addr = rd_addr_q (re-read keeps dout stable), rd_vld_q holds, counters hold.
  - RUN, no stall: mem_addr = issue address, rd_addr_q <= it, rd_vld_q <= 1, counters advance. Issuing the final word -> DRAIN.
  - DRAIN, stall: mem_addr = rd_addr_q.
  - DRAIN, no stall: rd_vld_q <= 0. Acceptance of the final word (valid_out && ready_in && frame_last) -> IDLE, with done = 1 in the next cycle.
- Throughput is one word per cycle with ready_in held high. Latency is 2 cycles from start sampled to first valid_out.
- mem_we = 0 outside IDLE. host_we outside IDLE is dropped and host_wr_err pulses the following cycle.
- start outside IDLE is ignored.
- abort, any state: next cycle IDLE, counters 0, rd_vld_q 0, tags 0, no done. abort has priority over start and completion in the same cycle.
- Tags:
  - block_first: r == 0.
  - block_last: r == DIM-1.
  - frame_last: last by, last bx, and r == DIM-1.
- Reset asserted mid-frame behaves as abort, asynchronously.

Test Plan:
- IMG_W=IMG_H=16, DIM=8, ready_in=1, start at cycle 0 -> valid_out from cycle 2 for 32 consecutive cycles. mem_addr sequence is 0,2,..,14, then 1,3,..,15, then 16,18,..,30, then 17,..,31. block_first on addresses 0,1,16,17. block_last on 14,15,30,31. frame_last only on 31. done at cycle 34.
- Same config, ready_in=0 for 3 cycles while the word at addr 4 is valid -> mem_addr held at 4, dout/valid_out stable. Sequence then resumes at 6 with no loss or duplication.
- IDLE, host_we=1, host_addr=5 -> mem_addr=5, mem_we=1. host_we during RUN -> mem_we=0, host_wr_err=1 one cycle later, and the frame sequence is unaffected.
- abort asserted while the word at addr 18 is valid -> next cycle busy=0, valid_out=0, no done. A new start then restarts from address 0.
- start pulsed again mid-frame -> ignored; one done only. rst_n low mid-frame -> outputs 0 immediately, state IDLE.
- Random ready_in (50%) over a full default 256x256 frame -> 8192 accepted words in block-raster order, exactly 1024 block_last tags, one frame_last, one done.
